// File: rtl/perceptron_sequencer.sv
// Sequences one perceptron datapath through a full neuron evaluation:
// holds weight/input/bias registers, streams element pairs, drains the pipeline, captures the result.
module perceptron_sequencer #(
  parameter int N_INPUTS     = 5,
  parameter int DRAIN_CYCLES = 12,
  parameter int AW           = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic          wr_err,
  input  logic          start,
  input  logic          act_sel,
  output logic          busy,
  output logic [31:0]   result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [31:0]   pcp_counter,
  output logic [31:0]   pcp_w,
  output logic [31:0]   pcp_x,
  output logic [31:0]   pcp_b,
  output logic          pcp_act,
  input  logic [31:0]   pcp_data_out
);

  // state  | meaning
  // IDLE   | registers writable, waiting for start
  // STREAM | presenting element idx (1..N_INPUTS) to the datapath
  // DRAIN  | waiting out the datapath pipeline
  // HOLD   | result valid, waiting for result_ready
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_HOLD} state_t;

  localparam int MAXC = (N_INPUTS > DRAIN_CYCLES) ? N_INPUTS : DRAIN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(N_INPUTS);
  localparam logic [CW-1:0] DRN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [AW:0]   N_LIM    = (AW + 1)'(N_INPUTS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic [31:0]   result_q, result_d;
  logic          valid_q, valid_d;
  logic          wr_err_q, wr_err_d;
  logic [31:0]   weight_q [N_INPUTS];
  logic [31:0]   input_q  [N_INPUTS];
  logic [31:0]   bias_q;
  logic          addr_ok;
  logic          wr_ok;
  logic [AW-1:0] elem;

  always_comb begin
    addr_ok = 1'b0;
    case (wr_sel)
      2'd0, 2'd1: addr_ok = ({1'b0, wr_addr} < N_LIM);
      2'd2:       addr_ok = 1'b1;
      default:    addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    result_d = result_q;
    valid_d  = valid_q;
    wr_ok    = 1'b0;
    wr_err_d = 1'b0;

    if (wr_en) begin
      if (state_q == S_IDLE && addr_ok) wr_ok = 1'b1;
      else                              wr_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          cnt_d   = CW'(1);
          act_d   = act_sel;
        end
      end
      S_STREAM: begin
        if (cnt_q == IDX_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRN_LAST) begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          result_d = pcp_data_out;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (result_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      act_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      wr_err_q <= wr_err_d;
    end
  end

  // A write accepted together with start lands here before the first stream cycle reads it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weight_q[i] <= '0;
        input_q[i]  <= '0;
      end
      bias_q <= '0;
    end else if (wr_ok) begin
      case (wr_sel)
        2'd0:    weight_q[wr_addr] <= wr_data;
        2'd1:    input_q[wr_addr]  <= wr_data;
        default: bias_q            <= wr_data;
      endcase
    end
  end

  assign elem = AW'(cnt_q - 1'b1);

  always_comb begin
    pcp_counter = '0;
    pcp_w       = '0;
    pcp_x       = '0;
    if (state_q == S_STREAM) begin
      pcp_counter = 32'(cnt_q);
      pcp_w       = weight_q[elem];
      pcp_x       = input_q[elem];
    end
  end

  assign pcp_b        = bias_q;
  assign pcp_act      = act_q;
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign wr_err       = wr_err_q;

endmodule
